// File: rtl/i2s_sample_capture.sv
// rtl/i2s_sample_capture.sv - I2S receiver: oversampled deframing of left/right words with lock and short-slot status
module i2s_sample_capture #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CHANNEL     = 0,
    parameter int TIMEOUT     = 1024
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i2s_sck,
    input  logic              i2s_ws,
    input  logic              i2s_sda,
    output logic [DATA_W-1:0] o_sample,
    output logic              o_ce,
    output logic [DATA_W-1:0] o_left,
    output logic [DATA_W-1:0] o_right,
    output logic              o_locked,
    output logic              o_short_err
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic {WAIT_SYNC, RUN} state_t;

    logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
    logic                   sck_s, ws_s, sd_s, sck_q;
    logic                   rise_r, ws_r, sd_r;

    state_t              state;
    logic [DATA_W-1:0]   shreg, sh_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [TO_W-1:0]     to_cnt;
    logic                ws_prev;
    logic                boundary;
    logic                pub, pub_full, pub_ch;
    logic [DATA_W-1:0]   pub_word;

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign ws_s  = ws_sync[SYNC_STAGES-1];
    assign sd_s  = sd_sync[SYNC_STAGES-1];

    // Synchronizers plus one register stage holding the detected rise and the bits sampled with it
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
            sck_q    <= 1'b0;
            rise_r   <= 1'b0;
            ws_r     <= 1'b0;
            sd_r     <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], i2s_sck};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], i2s_ws};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], i2s_sda};
            sck_q    <= sck_s;
            rise_r   <= sck_s & ~sck_q;
            ws_r     <= ws_s;
            sd_r     <= sd_s;
        end
    end

    always_comb begin
        sh_next  = shreg;
        cnt_next = cnt;
        if (cnt < CNT_W'(DATA_W)) begin
            sh_next  = {shreg[DATA_W-2:0], sd_r};
            cnt_next = cnt + 1'b1;
        end
    end

    assign boundary = rise_r && (ws_r != ws_prev);

    // Bit handling happens on the rise; the publish decision lands one cycle later from latched values
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state       <= WAIT_SYNC;
            shreg       <= '0;
            cnt         <= '0;
            to_cnt      <= '0;
            ws_prev     <= 1'b0;
            pub         <= 1'b0;
            pub_full    <= 1'b0;
            pub_ch      <= 1'b0;
            pub_word    <= '0;
            o_sample    <= '0;
            o_ce        <= 1'b0;
            o_left      <= '0;
            o_right     <= '0;
            o_locked    <= 1'b0;
            o_short_err <= 1'b0;
        end else begin
            pub         <= 1'b0;
            o_ce        <= 1'b0;
            o_short_err <= 1'b0;

            if (pub) begin
                if (pub_full) begin
                    if (pub_ch) o_right <= pub_word;
                    else        o_left  <= pub_word;
                    if (pub_ch == 1'(CHANNEL)) begin
                        o_sample <= pub_word;
                        o_ce     <= 1'b1;
                    end
                end else begin
                    o_short_err <= 1'b1;
                end
            end

            if (rise_r) begin
                to_cnt  <= '0;
                shreg   <= sh_next;
                cnt     <= cnt_next;
                ws_prev <= ws_r;
                if (boundary) begin
                    cnt <= '0;
                    if (state == WAIT_SYNC) begin
                        state    <= RUN;
                        o_locked <= 1'b1;
                    end else begin
                        pub      <= 1'b1;
                        pub_full <= (cnt_next == CNT_W'(DATA_W));
                        pub_ch   <= ws_prev;
                        pub_word <= sh_next;
                    end
                end
            end else begin
                if (to_cnt != TO_W'(TIMEOUT)) to_cnt <= to_cnt + 1'b1;
                if (state == RUN && to_cnt == TO_W'(TIMEOUT - 1)) begin
                    state    <= WAIT_SYNC;
                    o_locked <= 1'b0;
                    cnt      <= '0;
                end
            end
        end
    end
endmodule

// File: doc/i2s_sample_capture.md
Name: i2s_sample_capture

Overview:
- Receives the I2S microphone bitstream (SCK/WS/SD, asynchronous to the system clock), oversamples it in the i_clk domain, and deframes left/right words.
- Presents the selected channel as a 16-bit sample with a single-cycle strobe. These drive i_sample / i_ce of the FIR filter stage directly downstream.
- Also exports both channel registers plus lock and framing-error status.

Parameters:
- DATA_W, 16, sample width; MSB-first bits kept per slot.
- SYNC_STAGES, 2, flip-flops in each input synchronizer (≥2).
- CHANNEL, 0, channel driving o_sample/o_ce (0 = left/WS low, 1 = right/WS high).
- TIMEOUT, 1024, i_clk cycles without an SCK rising edge before lock is dropped.

Ports:
- i_clk  in  1  system clock; must be ≥4× SCK frequency; SCK high and low each ≥2 i_clk cycles.
- i_reset  in  1  synchronous, active-low reset.
- i2s_sck  in  1  I2S bit clock (async).
- i2s_ws  in  1  I2S word select (async); changes on SCK falling edge.
- i2s_sda  in  1  I2S serial data (async); MSB one SCK after WS change (Philips format).
- o_sample  out  DATA_W  last completed word of CHANNEL.
- o_ce  out  1  one-cycle pulse when o_sample updates.
- o_left  out  DATA_W  last completed left word.
- o_right  out  DATA_W  last completed right word.
- o_locked  out  1  high while framing is aligned.
- o_short_err  out  1  one-cycle pulse when a slot ends with fewer than DATA_W bits.

Behaviour:
- Reset (i_reset low at i_clk edge):
  - All outputs go to 0.
  - Synchronizers, shift register, bit counter and timeout counter clear.
  - The state machine enters WAIT_SYNC.
  - Reset takes effect mid-word; the partial word is discarded.
- Input path: sck, ws and sd each pass through SYNC_STAGES flops.
- Edge detect: an SCK rising edge is `sck_s & ~sck_q`. All work below happens only on rise cycles.
- Per rise cycle, in this order:
  - Sample ws_s and sd_s.
  - If bit count < DATA_W: shift sd into the LSB of the shift register and increment the count. Otherwise the bit is ignored; the count saturates at DATA_W.
  - Compare ws_s with ws_prev (the WS value at the previous rise). A difference is a word boundary. The bit sampled on the boundary rise belongs to the previous slot (it is that slot's LSB for 16-bit slots).
  - Update ws_prev with ws_s.
- States:
  - WAIT_SYNC:
    - Entered from reset and on timeout.
    - Shifting runs, but no word is published.
    - On the first word boundary: clear the count to 0 and go to RUN. o_locked goes to 1 in the same cycle as the boundary rise is processed.
  - RUN, on each word boundary:
    - If count == DATA_W: publish the shift register to o_left (ws_prev = 0) or o_right (ws_prev = 1).
    - If that channel equals CHANNEL, also load o_sample and pulse o_ce for exactly 1 cycle.
    - If count < DATA_W: pulse o_short_err. Registers are unchanged and there is no o_ce.
    - Then clear the count to 0.
    - Slots longer than DATA_W keep the first DATA_W bits (MSB-aligned truncation).
- Timeout:
  - A counter clears on every rise and otherwise increments, saturating.
  - Reaching TIMEOUT in RUN: return to WAIT_SYNC, drop o_locked, clear the count.
  - o_left, o_right and o_sample hold their values.
- Latency:
  - o_ce/o_sample/o_left/o_right update exactly SYNC_STAGES+2 i_clk cycles after the first i_clk edge that samples the raw boundary SCK high.
  - This assumes inputs meet ≥1-cycle setup in the bench.
- Simultaneous events:
  - Reset has priority over everything.
  - A boundary and a timeout cannot coincide, because a rise clears the timeout.
  - A boundary on the same rise that saturates the count counts that bit as included.
- o_ce is never high for two consecutive cycles. At most one o_ce occurs per I2S frame.

Test Plan:
- Reset: hold i_reset low 5 cycles while toggling SCK/WS/SD.
  - All outputs stay 0 throughout and 1 cycle after release; state is WAIT_SYNC.
- Lock, 16-bit slots: start mid-word, then send frames L = 0x8001, R = 0x7FFE.
  - First partial word: no o_ce.
  - o_locked rises at the first boundary.
  - At the following boundaries: o_left = 0x8001 with one o_ce, o_sample = 0x8001 (CHANNEL = 0); o_right = 0x7FFE with no o_ce.
- 32-bit slots: send L = 0xA5A5_1234, R = 0x0F0F_FFFF.
  - Expect o_left = 0xA5A5, o_right = 0x0F0F; no o_short_err.
- Short slot: in RUN, send a 12-bit left slot.
  - Expect an o_short_err pulse, o_left unchanged, no o_ce.
  - The next correct 16-bit left slot publishes normally.
- Timeout: stop SCK for TIMEOUT+2 cycles.
  - o_locked falls; o_left holds its value.
  - After SCK resumes, the first word is discarded and o_locked returns at the next boundary.
- Reset mid-word: assert i_reset after 8 bits of a left slot.
  - All outputs 0; the next word boundary only re-locks, with no o_ce.
  - The following complete word publishes.
